cc_param_bank: RTL

CC_PARAM_BANK -- requirements
Module: cc_param_bank

---
 rtl/cc_param_bank_if.sv | 22 ++
 rtl/cc_param_bank.sv | 101 ++++++++++
 2 files changed

// File: rtl/cc_param_bank_if.sv
// rtl/cc_param_bank_if.sv - CC message input and parameter bank output bundle
interface cc_param_bank_if #(
  parameter int N_PARAM = 4
);
  logic [6:0]             cc_num;
  logic [6:0]             cc_val;
  logic                   cc_valid;
  logic [14*N_PARAM-1:0]  param_val;
  logic [N_PARAM-1:0]     param_upd;
  logic                   load;
  logic [6:0]             load_arg;

  modport master (
    output cc_num, cc_val, cc_valid,
    input  param_val, param_upd, load, load_arg
  );

  modport slave (
    input  cc_num, cc_val, cc_valid,
    output param_val, param_upd, load, load_arg
  );
endinterface

// File: rtl/cc_param_bank.sv
// rtl/cc_param_bank.sv - MIDI CC to 7/14-bit parameter slot bank with load strobe
module cc_param_bank #(
  parameter int          N_PARAM = 4,
  parameter int          BASE_CC = 16,
  parameter int          HIRES   = 1,
  parameter int          LOAD_CC = 112,
  parameter logic [13:0] RST_VAL = 14'd0
) (
  input  logic           clk,
  input  logic           rst,
  cc_param_bank_if.slave bus
);
  localparam int RAC_CC = 121;

  localparam bit LOAD_CLASH =
    (LOAD_CC >= BASE_CC && LOAD_CC < BASE_CC + N_PARAM) ||
    (HIRES != 0 && LOAD_CC >= BASE_CC + 32 && LOAD_CC < BASE_CC + 32 + N_PARAM);
  localparam bit RAC_CLASH =
    (RAC_CC >= BASE_CC && RAC_CC < BASE_CC + N_PARAM) ||
    (HIRES != 0 && RAC_CC >= BASE_CC + 32 && RAC_CC < BASE_CC + 32 + N_PARAM);

  if (N_PARAM < 1 || N_PARAM > 16) begin : g_err_nparam
    $error("cc_param_bank: N_PARAM must be 1..16");
  end
  if (HIRES != 0 && BASE_CC + N_PARAM > 32) begin : g_err_hires
    $error("cc_param_bank: MSB slots must stay below CC 32 when HIRES=1");
  end
  if (BASE_CC + N_PARAM > 128) begin : g_err_top
    $error("cc_param_bank: slot range exceeds CC 127");
  end
  if (LOAD_CLASH) begin : g_err_load
    $error("cc_param_bank: LOAD_CC falls inside a slot range");
  end
  if (RAC_CLASH) begin : g_err_rac
    $error("cc_param_bank: CC 121 falls inside a slot range");
  end

  logic [13:0]        slot_q [N_PARAM];
  logic [N_PARAM-1:0] msb_seen_q;
  logic [N_PARAM-1:0] upd_q;
  logic               load_q;
  logic [6:0]         load_arg_q;

  logic [N_PARAM-1:0] msb_hit;
  logic [N_PARAM-1:0] lsb_hit;
  logic               rac_hit;
  logic               load_hit;

  always_comb begin
    rac_hit  = bus.cc_valid && (int'(bus.cc_num) == RAC_CC);
    load_hit = bus.cc_valid && (int'(bus.cc_num) == LOAD_CC);
    msb_hit  = '0;
    lsb_hit  = '0;
    for (int i = 0; i < N_PARAM; i++) begin
      msb_hit[i] = bus.cc_valid && (int'(bus.cc_num) == BASE_CC + i);
      lsb_hit[i] = (HIRES != 0) && bus.cc_valid && (int'(bus.cc_num) == BASE_CC + 32 + i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PARAM; i++) slot_q[i] <= RST_VAL;
      msb_seen_q <= '0;
      upd_q      <= '0;
      load_q     <= 1'b0;
      load_arg_q <= '0;
    end else begin
      upd_q  <= '0;
      load_q <= 1'b0;
      if (rac_hit) begin
        for (int i = 0; i < N_PARAM; i++) slot_q[i] <= RST_VAL;
        msb_seen_q <= '0;
        upd_q      <= '1;
      end else if (load_hit) begin
        load_q     <= 1'b1;
        load_arg_q <= bus.cc_val;
      end else begin
        for (int i = 0; i < N_PARAM; i++) begin
          if (msb_hit[i]) begin
            // MSB write clears the fine half, matching MIDI 14-bit pairing
            slot_q[i]     <= {bus.cc_val, 7'b0};
            msb_seen_q[i] <= 1'b1;
            upd_q[i]      <= 1'b1;
          end else if (lsb_hit[i]) begin
            // an LSB on its own never promotes the slot to msb_seen
            slot_q[i]     <= {slot_q[i][13:7], bus.cc_val};
            msb_seen_q[i] <= msb_seen_q[i];
            upd_q[i]      <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_PARAM; g++) begin : g_out
    assign bus.param_val[14*g +: 14] = slot_q[g];
  end
  assign bus.param_upd = upd_q;
  assign bus.load      = load_q;
  assign bus.load_arg  = load_arg_q;
endmodule
